axis_vid_frame_gate: RTL and testbench

Per-stream input conditioner placed directly upstream of each input port of the two-stream AXIS video overlay. It discards pixels until a start-of-frame (tuser[0]) beat arrives, then passes whole frames through a small first-word-fall-through FIFO. It also counts line-length and early-SOF framing errors. A resync request flushes the stage and re-hunts for SOF, so two instances can be re-aligned to a common frame boundary before merging.

---
 rtl/axis_vid_pkg.sv | 16 +
 rtl/axis_vid_fwft_fifo.sv | 53 +++++
 rtl/axis_vid_frame_gate.sv | 106 ++++++++++
 tb/tb_axis_vid_frame_gate.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_vid_pkg.sv
// Shared types and constants for the AXIS video frame gate slice.
package axis_vid_pkg;

    typedef enum logic {
        SEEK = 1'b0,
        PASS = 1'b1
    } vid_state_t;

    localparam int SOF_BIT   = 0;
    localparam int ERR_CNT_W = 8;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/axis_vid_fwft_fifo.sv
// First-word-fall-through FIFO with registered full/empty flags and a
// synchronous flush that clears both pointers.
module axis_vid_fwft_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic             do_wr, do_rd;

    always_comb begin
        do_wr  = wr_en & ~full;
        do_rd  = rd_en & ~empty;
        wr_nxt = flush ? '0 : wr_ptr + PW'(do_wr);
        rd_nxt = flush ? '0 : rd_ptr + PW'(do_rd);
    end

    // Flags are computed from next pointers so they are plain registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            full   <= (wr_nxt - rd_nxt) == PW'(DEPTH);
            empty  <= (wr_nxt == rd_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/axis_vid_frame_gate.sv
// Drops pixels until SOF, then forwards whole frames through a FWFT FIFO while
// counting framing errors. Define AXIS_VID_TLAST_REGEN_EN to regenerate tlast.
module axis_vid_frame_gate
    import axis_vid_pkg::*;
#(
    parameter int DATA_WIDTH  = 24,
    parameter int USER_WIDTH  = 1,
    parameter int FIFO_DEPTH  = 16,
    parameter int LINE_PIXELS = 1920
) (
    input  logic                  axis_clk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  resync,
    output logic                  locked,
    output logic [ERR_CNT_W-1:0]  err_line_cnt,
    output logic [ERR_CNT_W-1:0]  err_sof_cnt
);
    localparam int CNT_W = $clog2(LINE_PIXELS) + 1;
    localparam int FW    = DATA_WIDTH + 1 + USER_WIDTH;
    localparam logic [CNT_W-1:0] LINE_LEN = CNT_W'(LINE_PIXELS);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    vid_state_t        state;
    logic [CNT_W-1:0]  pix_cnt;
    logic              in_ok;
    logic              fifo_full, fifo_empty;
    logic [FW-1:0]     fifo_rd_data;
    logic              sof, accept, wr_en, pos_last, out_tlast;
    logic [CNT_W-1:0]  base, pos;

    // pos is the 1-based position of the current beat; a SOF restarts the line
    // and the count saturates so an unterminated line can never alias LINE_LEN.
    always_comb begin
        sof      = s_axis_tuser[SOF_BIT];
        accept   = s_axis_tvalid & s_axis_tready;
        wr_en    = accept & ~resync & ((state == PASS) | sof);
        base     = sof ? '0 : pix_cnt;
        pos      = (base == CNT_MAX) ? base : base + CNT_W'(1);
        pos_last = (pos == LINE_LEN);
`ifdef AXIS_VID_TLAST_REGEN_EN
        out_tlast = pos_last;
`else
        out_tlast = s_axis_tlast;
`endif
    end

    assign s_axis_tready = in_ok & ((state == SEEK) | ~fifo_full);
    assign m_axis_tvalid = ~fifo_empty;
    assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = fifo_rd_data;

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            state        <= SEEK;
            locked       <= 1'b0;
            pix_cnt      <= '0;
            in_ok        <= 1'b0;
            err_line_cnt <= '0;
            err_sof_cnt  <= '0;
        end else begin
            in_ok <= 1'b1;
            if (resync) begin
                state   <= SEEK;
                locked  <= 1'b0;
                pix_cnt <= '0;
            end else if (wr_en) begin
                state  <= PASS;
                locked <= 1'b1;
                if (sof && pix_cnt != '0)
                    err_sof_cnt <= sat_inc(err_sof_cnt);
                if (s_axis_tlast && !pos_last)
                    err_line_cnt <= sat_inc(err_line_cnt);
`ifdef AXIS_VID_TLAST_REGEN_EN
                pix_cnt <= pos_last ? '0 : pos;
`else
                pix_cnt <= s_axis_tlast ? '0 : pos;
`endif
            end
        end
    end

    axis_vid_fwft_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (axis_clk),
        .rst     (areset),
        .flush   (resync),
        .wr_en   (wr_en),
        .wr_data ({s_axis_tdata, out_tlast, s_axis_tuser}),
        .rd_en   (m_axis_tready),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_axis_vid_frame_gate.sv
// Self-checking bench for axis_vid_frame_gate: directed table, hand sequences
// and randomized traffic against a queue-based behavioural model.
module tb_axis_vid_frame_gate;
    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int LINE  = 4;

    logic          axis_clk = 1'b0;
    logic          areset   = 1'b1;
    logic [DW-1:0] s_axis_tdata  = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast  = 1'b0;
    logic [0:0]    s_axis_tuser  = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [0:0]    m_axis_tuser;
    logic          resync = 1'b0;
    logic          locked;
    logic [7:0]    err_line_cnt, err_sof_cnt;

    axis_vid_frame_gate #(
        .DATA_WIDTH  (DW),
        .USER_WIDTH  (1),
        .FIFO_DEPTH  (DEPTH),
        .LINE_PIXELS (LINE)
    ) dut (
        .axis_clk      (axis_clk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .resync        (resync),
        .locked        (locked),
        .err_line_cnt  (err_line_cnt),
        .err_sof_cnt   (err_sof_cnt)
    );

    always #5 axis_clk = ~axis_clk;

`ifdef AXIS_VID_TLAST_REGEN_EN
    localparam bit REGEN = 1'b1;
`else
    localparam bit REGEN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    // Behavioural model: FIFO contents as a queue, line position as an integer.
    beat_t mq[$];
    bit    mdl_locked;
    bit    mdl_inok;
    int    mdl_pos;
    int    mdl_eline;
    int    mdl_esof;

    typedef struct {
        logic          vld;
        logic [DW-1:0] d;
        logic          lst;
        logic          sf;
        logic          e_lock;
        logic          e_vld;
        logic [DW-1:0] e_d;
        logic          e_last;
        logic          e_user;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic vld, logic [DW-1:0] d, logic lst, logic sf,
                                logic e_lock, logic e_vld, logic [DW-1:0] e_d,
                                logic e_last, logic e_user);
        vec_t v;
        v.vld = vld; v.d = d; v.lst = lst; v.sf = sf;
        v.e_lock = e_lock; v.e_vld = e_vld; v.e_d = e_d;
        v.e_last = e_last; v.e_user = e_user;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    task automatic model_reset();
        mq.delete();
        mdl_locked = 0;
        mdl_inok   = 0;
        mdl_pos    = 0;
        mdl_eline  = 0;
        mdl_esof   = 0;
    endtask

    task automatic check_all();
        logic exp_rdy;
        exp_rdy = mdl_inok && (!mdl_locked || mq.size() < DEPTH);
        chk("s_tready", {31'd0, s_axis_tready}, {31'd0, exp_rdy});
        chk("m_tvalid", {31'd0, m_axis_tvalid}, (mq.size() > 0) ? 32'd1 : 32'd0);
        chk("locked", {31'd0, locked}, {31'd0, mdl_locked});
        chk("err_line", {24'd0, err_line_cnt}, mdl_eline);
        chk("err_sof", {24'd0, err_sof_cnt}, mdl_esof);
        if (mq.size() > 0)
            chk("m_head", {6'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                {6'd0, mq[0].d, mq[0].l, mq[0].u});
    endtask

    // Drive one cycle of inputs (called at posedge+1), advance the model, check.
    task automatic cycle(input logic vld, input logic [DW-1:0] d, input logic lst,
                         input logic sf, input logic mr, input logic rs);
        logic  p_rdy, p_vld;
        int    p;
        beat_t b;
        s_axis_tvalid = vld;
        s_axis_tdata  = d;
        s_axis_tlast  = lst;
        s_axis_tuser  = sf;
        m_axis_tready = mr;
        resync        = rs;
        p_rdy = mdl_inok && (!mdl_locked || mq.size() < DEPTH);
        p_vld = (mq.size() > 0);
        @(posedge axis_clk);
        if (p_vld && mr)
            void'(mq.pop_front());
        if (rs) begin
            mq.delete();
            mdl_locked = 0;
            mdl_pos    = 0;
        end else if (p_rdy && vld && (mdl_locked || sf)) begin
            if (sf && mdl_pos != 0)
                mdl_esof = sat(mdl_esof);
            p = sf ? 1 : mdl_pos + 1;
            if (lst && p != LINE)
                mdl_eline = sat(mdl_eline);
            b.d = d;
            b.u = sf;
            if (REGEN) begin
                b.l     = (p == LINE);
                mdl_pos = (p == LINE) ? 0 : p;
            end else begin
                b.l     = lst;
                mdl_pos = lst ? 0 : p;
            end
            mq.push_back(b);
            mdl_locked = 1;
        end
        mdl_inok = 1;
        #1;
        check_all();
    endtask

    task automatic idle(input logic mr);
        cycle(1'b0, '0, 1'b0, 1'b0, mr, 1'b0);
    endtask

    task automatic do_reset();
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        resync        = 1'b0;
        #1;
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rst_outs", {6'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_errs", {16'd0, err_line_cnt, err_sof_cnt}, 32'd0);
        model_reset();
        @(posedge axis_clk);
        #1;
        areset = 1'b0;
        idle(1'b0);
        chk("post_rst_tready", {31'd0, s_axis_tready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        int            nacc;
        int            idx;
        logic [DW-1:0] d;

        for (int i = 0; i < 5; i++)
            vecs[i] = mk(1, 24'h0000A0 + DW'(i), 0, 0, 0, 0, '0, 0, 0);
        vecs[5] = mk(1, 24'h000100, 0, 1, 1, 1, 24'h000100, 0, 1);
        for (int i = 6; i < 13; i++)
            vecs[i] = mk(1, 24'h000100 + DW'(i - 5), (i == 8 || i == 12), 0,
                         1, 1, 24'h000100 + DW'(i - 5), (i == 8 || i == 12), 0);
        vecs[13] = mk(0, '0, 0, 0, 1, 0, '0, 0, 0);

        model_reset();
        @(posedge axis_clk);
        #1;

        // Drop-until-SOF directed table.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(vecs[i].vld, vecs[i].d, vecs[i].lst, vecs[i].sf, 1'b1, 1'b0);
            chk($sformatf("vec%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].e_lock});
            chk($sformatf("vec%0d_valid", i), {31'd0, m_axis_tvalid}, {31'd0, vecs[i].e_vld});
            if (vecs[i].e_vld)
                chk($sformatf("vec%0d_beat", i), {6'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                    {6'd0, vecs[i].e_d, vecs[i].e_last, vecs[i].e_user});
        end

        // Backpressure: FIFO fills after DEPTH beats, ready returns after first read.
        do_reset();
        nacc = 0;
        idx  = 0;
        for (int c = 0; c < 8; c++) begin
            logic acc;
            acc = s_axis_tready;
            cycle(1'b1, 24'h000200 + DW'(idx), (idx % 4 == 3), (idx == 0), 1'b0, 1'b0);
            if (acc) begin
                nacc++;
                idx++;
            end
        end
        chk("bp_accepted", nacc, DEPTH);
        chk("bp_tready_low", {31'd0, s_axis_tready}, 32'd0);
        chk("bp_head0", {8'd0, m_axis_tdata}, 32'h200);
        for (int k = 1; k <= 4; k++) begin
            idle(1'b1);
            if (k == 1)
                chk("bp_ready_return", {31'd0, s_axis_tready}, 32'd1);
            if (k < 4)
                chk($sformatf("bp_head%0d", k), {8'd0, m_axis_tdata}, 32'h200 + k);
        end
        chk("bp_drained", {31'd0, m_axis_tvalid}, 32'd0);

        // Short line: tlast on pixel 3.
        do_reset();
        cycle(1, 24'h000300, 0, 1, 1, 0);
        cycle(1, 24'h000301, 0, 0, 1, 0);
        cycle(1, 24'h000302, 1, 0, 1, 0);
        chk("short_err_line", {24'd0, err_line_cnt}, 32'd1);
        chk("short_fwd", {8'd0, m_axis_tdata}, 32'h302);
        chk("short_tlast3", {31'd0, m_axis_tlast}, REGEN ? 32'd0 : 32'd1);
        cycle(1, 24'h000303, 0, 0, 1, 0);
        chk("short_tlast4", {31'd0, m_axis_tlast}, REGEN ? 32'd1 : 32'd0);
        idle(1'b1);

        // Early SOF on pixel 2: counter restarts at 1.
        do_reset();
        cycle(1, 24'h000400, 0, 1, 1, 0);
        cycle(1, 24'h000401, 0, 1, 1, 0);
        chk("esof_cnt", {24'd0, err_sof_cnt}, 32'd1);
        cycle(1, 24'h000402, 0, 0, 1, 0);
        cycle(1, 24'h000403, 0, 0, 1, 0);
        cycle(1, 24'h000404, 1, 0, 1, 0);
        chk("esof_line_ok", {24'd0, err_line_cnt}, 32'd0);
        chk("esof_tlast", {31'd0, m_axis_tlast}, 32'd1);
        idle(1'b1);

        // Resync with 3 beats buffered.
        do_reset();
        cycle(1, 24'h000500, 0, 1, 0, 0);
        cycle(1, 24'h000501, 0, 1, 0, 0);
        cycle(1, 24'h000502, 0, 0, 0, 0);
        chk("rs_buffered", {31'd0, m_axis_tvalid}, 32'd1);
        cycle(1, 24'h000503, 0, 0, 0, 1);
        chk("rs_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rs_locked", {31'd0, locked}, 32'd0);
        for (int k = 0; k < 3; k++)
            cycle(1, 24'h000510 + DW'(k), 0, 0, 1, 0);
        chk("rs_dropped", {31'd0, m_axis_tvalid}, 32'd0);
        chk("rs_err_kept", {24'd0, err_sof_cnt}, 32'd1);
        cycle(1, 24'h000520, 0, 1, 0, 0);
        chk("rs_relock", {8'd0, m_axis_tdata, 7'd0, m_axis_tuser}, 32'h052001);

        // Saturation: 400 three-pixel lines, then areset mid-stream.
        do_reset();
        for (int n = 0; n < 400; n++)
            for (int k = 0; k < 3; k++)
                cycle(1, DW'(n * 3 + k), (k == 2), (n == 0 && k == 0), 1, 0);
        chk("sat_err_line", {24'd0, err_line_cnt}, 32'd255);
        cycle(1, 24'h5A5A5A, 0, 0, 0, 0);
        chk("pre_areset_valid", {31'd0, m_axis_tvalid}, 32'd1);
        #2;
        areset = 1'b1;
        #1;
        chk("ar_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("ar_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        chk("ar_outs", {6'd0, m_axis_tdata, m_axis_tlast, m_axis_tuser}, 32'd0);
        chk("ar_locked", {31'd0, locked}, 32'd0);
        chk("ar_errs", {16'd0, err_line_cnt, err_sof_cnt}, 32'd0);
        @(posedge axis_clk);
        #1;

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            d = DW'($urandom);
            cycle(($urandom_range(9) < 7), d, ($urandom_range(4) == 0),
                  ($urandom_range(19) == 0), ($urandom_range(9) < 6),
                  ($urandom_range(99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
